// File: rtl/jtframe_joy_pkg.sv
// Shared definitions for the DB9 joystick scan path.
// Player word bit positions, DB9 bus bit positions and the scan phase encoding.
// Purely declarative; no timing or backpressure of its own.
package jtframe_joy_pkg;

    // Active-high player word: MX YZS ACB UDLR
    localparam int JOY_R = 0;
    localparam int JOY_L = 1;
    localparam int JOY_D = 2;
    localparam int JOY_U = 3;
    localparam int JOY_B = 4;
    localparam int JOY_C = 5;
    localparam int JOY_A = 6;
    localparam int JOY_S = 7;
    localparam int JOY_Z = 8;
    localparam int JOY_Y = 9;
    localparam int JOY_X = 10;
    localparam int JOY_M = 11;

    // Active-low DB9 bus as seen by the FPGA
    localparam int DB9_U  = 0;
    localparam int DB9_D  = 1;
    localparam int DB9_L  = 2;
    localparam int DB9_R  = 3;
    localparam int DB9_P6 = 4;
    localparam int DB9_P9 = 5;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        P0   = 4'd1,
        P1   = 4'd2,
        P2   = 4'd3,
        P3   = 4'd4,
        P4   = 4'd5,
        P5   = 4'd6,
        P6   = 4'd7,
        P7   = 4'd8
    } scan_phase_t;

    // Select is low in the even scan phases and high everywhere else,
    // including the idle rest that lets 6-button pads time out.
    function automatic logic phase_select(input scan_phase_t ph);
        logic sel;
        case (ph)
            P0, P2, P4, P6: sel = 1'b0;
            default:        sel = 1'b1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtframe_db9_decode.sv
// Per-port DB9 decoder: builds a shadow player word from phase-end samples, commits it once per frame.
// Latency: shadow updates on the sampling cycle; player/six update on the cycle after commit.
// No backpressure: samples whenever strobed. Ports: clk/reset, bus (synced, active-low), phase, sample, commit -> player, six.
module jtframe_db9_decode
    import jtframe_joy_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   bus,
    input  scan_phase_t  phase,
    input  logic         sample,
    input  logic         commit,
    output logic [11:0]  player,
    output logic         six
);

    logic [5:0]  act;
    logic [11:0] shadow_q;
    logic        sega_q;
    logic        six_q;
    logic        lr_low;

    assign act    = ~bus;
    // During the first select-low phase a Sega pad grounds L and R;
    // an Atari pad only does that if both are pressed at once.
    assign lr_low = act[DB9_L] & act[DB9_R];

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            sega_q   <= 1'b0;
            six_q    <= 1'b0;
            player   <= '0;
            six      <= 1'b0;
        end else begin
            if (sample) begin
                case (phase)
                    P0: begin
                        sega_q          <= lr_low;
                        shadow_q[JOY_A] <= lr_low & act[DB9_P6];
                        shadow_q[JOY_S] <= lr_low & act[DB9_P9];
                    end
                    P1: begin
                        shadow_q[JOY_U] <= act[DB9_U];
                        shadow_q[JOY_D] <= act[DB9_D];
                        shadow_q[JOY_L] <= act[DB9_L];
                        shadow_q[JOY_R] <= act[DB9_R];
                        shadow_q[JOY_B] <= act[DB9_P6];
                        shadow_q[JOY_C] <= act[DB9_P9];
                    end
                    P4: begin
                        // Third select-low: a 6-button pad drives all of UDLR low
                        six_q <= sega_q & act[DB9_U] & act[DB9_D] & act[DB9_L] & act[DB9_R];
                    end
                    P5: begin
                        // Third select-high: UDLR lines carry Z, Y, X, Mode
                        shadow_q[JOY_Z] <= six_q & act[DB9_U];
                        shadow_q[JOY_Y] <= six_q & act[DB9_D];
                        shadow_q[JOY_X] <= six_q & act[DB9_L];
                        shadow_q[JOY_M] <= six_q & act[DB9_R];
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                player <= shadow_q;
                six    <= six_q;
            end
        end
    end

endmodule

// File: rtl/jtframe_db9_sega_scan.sv
// DB9 Sega/Atari joystick scanner: drives select through IDLE + 8 phases, decodes two ports.
// Latency: player words, six_btn and frame_done appear one cycle after the last P7 sample.
// No backpressure: free-running frame, outputs held stable between frame_done pulses.
// Ports: clk_sys, reset (sync, active-high), joy1_bus/joy2_bus (active-low DB9) ->
//        joy_select, player1/player2 (MX YZS ACB UDLR), six_btn, frame_done.
module jtframe_db9_sega_scan
    import jtframe_joy_pkg::*;
#(
    parameter int CLK_KHZ  = 50000,
    parameter int PHASE_US = 8,
    parameter int IDLE_US  = 2000
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [5:0]   joy1_bus,
    input  logic [5:0]   joy2_bus,
    output logic         joy_select,
    output logic [11:0]  player1,
    output logic [11:0]  player2,
    output logic [1:0]   six_btn,
    output logic         frame_done
);

    localparam int PHASE_CYC = CLK_KHZ * PHASE_US / 1000;
    localparam int IDLE_CYC  = CLK_KHZ * IDLE_US / 1000;
    localparam int CNT_MAX   = (PHASE_CYC > IDLE_CYC) ? PHASE_CYC : IDLE_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    scan_phase_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last;
    logic              sample;
    logic              commit;
    logic              sel_q;
    logic              done_q;
    logic [5:0]        sync1_a_q, sync2_a_q;
    logic [5:0]        sync1_b_q, sync2_b_q;

    // State and phase counter registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter runs 0..len-1 and wraps to 0 on each transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (state_q == IDLE)
            last = (cnt_q == CNT_W'(IDLE_CYC - 1));
        else
            last = (cnt_q == CNT_W'(PHASE_CYC - 1));
        sample = last && (state_q != IDLE);
        commit = last && (state_q == P7);
        if (last) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE:    state_d = P0;
                P0:      state_d = P1;
                P1:      state_d = P2;
                P2:      state_d = P3;
                P3:      state_d = P4;
                P4:      state_d = P5;
                P5:      state_d = P6;
                P6:      state_d = P7;
                P7:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Select is registered from the next state so it flips exactly on
    // the first cycle of each phase without a combinational glitch.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sel_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            sel_q  <= phase_select(state_d);
            done_q <= commit;
        end
    end

    // Two-flop synchronizers; idle value is all-high (released lines)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_a_q <= '1;
            sync2_a_q <= '1;
            sync1_b_q <= '1;
            sync2_b_q <= '1;
        end else begin
            sync1_a_q <= joy1_bus;
            sync2_a_q <= sync1_a_q;
            sync1_b_q <= joy2_bus;
            sync2_b_q <= sync1_b_q;
        end
    end

    jtframe_db9_decode u_dec1 (
        .clk    (clk_sys),
        .reset  (reset),
        .bus    (sync2_a_q),
        .phase  (state_q),
        .sample (sample),
        .commit (commit),
        .player (player1),
        .six    (six_btn[0])
    );

    jtframe_db9_decode u_dec2 (
        .clk    (clk_sys),
        .reset  (reset),
        .bus    (sync2_b_q),
        .phase  (state_q),
        .sample (sample),
        .commit (commit),
        .player (player2),
        .six    (six_btn[1])
    );

    assign joy_select = sel_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_jtframe_db9_sega_scan.sv
// Bench for jtframe_db9_sega_scan with scaled-down timing (8-cycle phases, 24-cycle idle).
// Pads are modelled behaviourally (Atari / Sega 3-button / Sega 6-button reacting to select).
// A frame-position model predicts select, frame_done and committed words every cycle.
module tb_jtframe_db9_sega_scan;
    import jtframe_joy_pkg::*;

    localparam int CLK_KHZ  = 1000;
    localparam int PHASE_US = 8;
    localparam int IDLE_US  = 24;
    localparam int P        = CLK_KHZ * PHASE_US / 1000;
    localparam int I        = CLK_KHZ * IDLE_US / 1000;
    localparam int FRAME    = I + 8 * P;

    localparam int T_NONE  = 0;
    localparam int T_ATARI = 1;
    localparam int T_3B    = 2;
    localparam int T_6B    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  joy1_bus, joy2_bus;
    logic        joy_select;
    logic [11:0] player1, player2;
    logic [1:0]  six_btn;
    logic        frame_done;

    int          type1 = T_NONE;
    int          type2 = T_NONE;
    logic [11:0] btn1 = '0;
    logic [11:0] btn2 = '0;

    int checks = 0;
    int errors = 0;

    jtframe_db9_sega_scan #(
        .CLK_KHZ  (CLK_KHZ),
        .PHASE_US (PHASE_US),
        .IDLE_US  (IDLE_US)
    ) dut (
        .clk_sys    (clk),
        .reset      (reset),
        .joy1_bus   (joy1_bus),
        .joy2_bus   (joy2_bus),
        .joy_select (joy_select),
        .player1    (player1),
        .player2    (player2),
        .six_btn    (six_btn),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- pad model ----------------
    // n = number of select falling edges in the current burst; a long high resets it
    int  sel_falls = 0;
    time last_rise = 0;

    always @(posedge joy_select) last_rise = $time;
    always @(negedge joy_select) begin
        if (($time - last_rise) > 150) sel_falls = 1;
        else                            sel_falls = sel_falls + 1;
    end

    function automatic logic [5:0] pad_bus(input int typ, input logic [11:0] b,
                                           input int n, input logic sel);
        logic [5:0] h;
        h = {b[JOY_C], b[JOY_B], b[JOY_R], b[JOY_L], b[JOY_D], b[JOY_U]};
        if (typ == T_NONE) begin
            h = '0;
        end else if (typ == T_3B || typ == T_6B) begin
            if (sel === 1'b0) begin
                if (typ == T_6B && n == 3)      h = {b[JOY_S], b[JOY_A], 4'b1111};
                else if (typ == T_6B && n == 4) h = {b[JOY_S], b[JOY_A], 4'b0000};
                else h = {b[JOY_S], b[JOY_A], 1'b1, 1'b1, b[JOY_D], b[JOY_U]};
            end else if (typ == T_6B && n == 3) begin
                h = {b[JOY_C], b[JOY_B], b[JOY_M], b[JOY_X], b[JOY_Y], b[JOY_Z]};
            end
        end
        return ~h;
    endfunction

    assign joy1_bus = pad_bus(type1, btn1, sel_falls, joy_select);
    assign joy2_bus = pad_bus(type2, btn2, sel_falls, joy_select);

    // What a pad of a given type can report in the player word
    function automatic logic [11:0] expect_word(input int typ, input logic [11:0] b);
        case (typ)
            T_ATARI: return b & 12'h03F;
            T_3B:    return b & 12'h0FF;
            T_6B:    return b;
            default: return 12'h000;
        endcase
    endfunction

    // ---------------- frame model ----------------
    int          idx = 0;
    bit          mdl_on = 1'b0;
    logic [11:0] nxt1 = '0, nxt2 = '0, out1 = '0, out2 = '0;
    logic [1:0]  nxt6 = '0, out6 = '0;

    always @(posedge clk) begin
        if (reset) begin
            idx    = 0;
            mdl_on = 1'b1;
        end else begin
            idx = idx + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (frame pos %0d)", name, act, exp, idx);
        end
    endtask

    always @(negedge clk) begin
        int   t;
        logic exp_sel;
        logic exp_fd;
        if (mdl_on) begin
            t = idx % FRAME;
            if (idx == 0) begin
                out1 = '0; out2 = '0; out6 = '0;
            end
            // Buttons are held from the start of P0 until past the P5 sample
            if (t == I) begin
                nxt1 = expect_word(type1, btn1);
                nxt2 = expect_word(type2, btn2);
                nxt6 = {type2 == T_6B, type1 == T_6B};
            end
            if (t == 0 && idx > 0) begin
                out1 = nxt1; out2 = nxt2; out6 = nxt6;
            end
            exp_sel = (t < I) ? 1'b1 : (((t - I) / P) % 2 == 1);
            exp_fd  = (t == 0 && idx > 0);
            chk("select",     32'(joy_select), 32'(exp_sel));
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            chk("player1",    32'(player1),    32'(out1));
            chk("player2",    32'(player2),    32'(out2));
            chk("six_btn",    32'(six_btn),    32'(out6));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic goto_t(input int tt);
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if ((idx % FRAME) == tt) return;
        end
        chk("goto_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(output int at_idx);
        at_idx = -1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                at_idx = idx;
                return;
            end
        end
        chk("frame_done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int fd_at;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle buses: first commit after exactly one idle rest plus 8 phases
        wait_done(fd_at);
        chk("first_done_pos", 32'(fd_at), 32'(FRAME));
        chk("p1_idle", 32'(player1), 32'h000);
        chk("p2_idle", 32'(player2), 32'h000);
        chk("six_idle", 32'(six_btn), 32'h0);

        // Atari pad on port 1: Up + pin6
        goto_t(2);
        type1 = T_ATARI;
        btn1  = 12'h018;
        goto_t(1);
        chk("atari_p1", 32'(player1), 32'h018);
        chk("atari_six", 32'(six_btn), 32'h0);

        // 3-button pad on port 1: A + Start
        goto_t(2);
        type1 = T_3B;
        btn1  = 12'h0C0;
        goto_t(1);
        chk("sega3_p1", 32'(player1), 32'h0C0);
        chk("sega3_six", 32'(six_btn), 32'h0);

        // 6-button pad on port 2: Start + X
        goto_t(2);
        type2 = T_6B;
        btn2  = 12'h480;
        goto_t(1);
        chk("sega6_p2", 32'(player2), 32'h480);
        chk("sega6_six", 32'(six_btn), 32'h2);
        chk("sega6_p1_kept", 32'(player1), 32'h0C0);

        // Reset in the middle of P3 with buttons still held
        goto_t(I + 3 * P + 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_p1", 32'(player1), 32'h000);
        chk("rst_p2", 32'(player2), 32'h000);
        chk("rst_six", 32'(six_btn), 32'h0);
        chk("rst_sel", 32'(joy_select), 32'h1);
        wait_done(fd_at);
        chk("rst_done_pos", 32'(fd_at), 32'(FRAME));
        chk("rst_p1_back", 32'(player1), 32'h0C0);
        chk("rst_p2_back", 32'(player2), 32'h480);
        chk("rst_six_back", 32'(six_btn), 32'h2);

        // Change port 1 buttons during P6: this frame's commit keeps the old word
        goto_t(I + 6 * P + 1);
        btn1 = 12'h030;
        goto_t(1);
        chk("late_p1_old", 32'(player1), 32'h0C0);
        chk("late_done_width", 32'(frame_done), 32'h0);
        goto_t(1);
        chk("late_p1_new", 32'(player1), 32'h030);

        // Unplug port 2
        goto_t(2);
        type2 = T_NONE;
        btn2  = '0;
        goto_t(1);
        chk("unplug_p2", 32'(player2), 32'h000);
        chk("unplug_six", 32'(six_btn), 32'h0);
        chk("unplug_p1", 32'(player1), 32'h030);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
